fetch_32i: RTL

Instruction fetch unit for the OpenRISC-compatible core. It is the producer side of the instruction interface that feeds decode_32i.
- Generates word-aligned fetch addresses and reads instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents them with their PC to the decoder on a valid/ready handshake.
- Handles branch redirect (flush) and bus errors.

---
 rtl/fetch_32i.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_32i.sv
// -----------------------------------------------------------------------------
// fetch_32i - instruction fetch unit feeding decode_32i.
//
// Issues word-aligned reads to instruction memory over a req/ack handshake with
// at most one request in flight. It buffers returned words with their PC in a
// small FIFO and presents the FIFO head to the decoder on a valid/ready
// handshake. A redirect flushes the FIFO and restarts fetch at a new PC. A bus
// error halts fetching until the next redirect.
//
// Ports:
//   clk_in            core clock, rising edge
//   reset_in          asynchronous active-low reset
//   redirect_in       one-cycle branch/exception redirect strobe
//   redirect_pc_in    new fetch address (low two bits ignored)
//   mem_req_out       instruction memory read request
//   mem_addr_out      fetch address (word aligned)
//   mem_ack_in        read complete, data/err valid this cycle
//   mem_data_in       instruction word
//   mem_err_in        bus error on this read (qualified by ack)
//   inst_out          FIFO head instruction (0 when empty or faulted)
//   inst_pc_out       PC of the head instruction (0 when empty)
//   inst_valid_out    FIFO head valid
//   inst_ready_in     decoder accepts the head this cycle
//   flag_bus_err_out  head entry faulted
// -----------------------------------------------------------------------------
module fetch_32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0100,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_data_in,
    input  logic        mem_err_in,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc_out,
    output logic        inst_valid_out,
    input  logic        inst_ready_in,
    output logic        flag_bus_err_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t          state_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     addr_q;
    logic            req_q;

    logic [31:0]     fifo_data_q [DEPTH];
    logic [31:0]     fifo_pc_q   [DEPTH];
    logic [DEPTH-1:0] fifo_err_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic [31:0]     redirect_pc_s;
    logic [31:0]     pc_inc_s;
    logic            valid_s;
    logic            push_s;
    logic            pop_s;
    logic            has_free_s;
    logic            free_after_s;

    assign redirect_pc_s = redirect_pc_in & 32'hFFFF_FFFC;
    // Natural 32-bit overflow gives the 0xFFFFFFFC -> 0 wrap.
    assign pc_inc_s      = fetch_pc_q + 32'd4;
    assign valid_s       = (count_q != {CW{1'b0}});
    // A redirect discards any same-cycle push or pop.
    assign push_s        = (state_q == ST_REQ) & mem_ack_in & ~redirect_in;
    assign pop_s         = valid_s & inst_ready_in & ~redirect_in;
    assign has_free_s    = (count_q < CW'(DEPTH));
    assign free_after_s  = (count_d < CW'(DEPTH));

    // FIFO occupancy after this cycle's push, pop or flush.
    always_comb begin
        count_d = count_q;
        if (redirect_in) begin
            count_d = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
            if (redirect_in) begin
                wr_ptr_q <= {AW{1'b0}};
                rd_ptr_q <= {AW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
        end
    end

    // FIFO storage; a faulted read stores a zero instruction word.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= 32'h0000_0000;
                fifo_pc_q[i]   <= 32'h0000_0000;
            end
            fifo_err_q <= {DEPTH{1'b0}};
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= mem_err_in ? 32'h0000_0000 : mem_data_in;
            fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
            fifo_err_q[wr_ptr_q]  <= mem_err_in;
        end
    end

    // Fetch sequencer: control state, fetch PC and the registered bus request.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect_in) begin
                        fetch_pc_q <= redirect_pc_s;
                        addr_q     <= redirect_pc_s;
                        req_q      <= 1'b1;
                        state_q    <= ST_REQ;
                    end else if (has_free_s) begin
                        addr_q  <= fetch_pc_q;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end else begin
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_ack_in) begin
                        if (redirect_in) begin
                            fetch_pc_q <= redirect_pc_s;
                            addr_q     <= redirect_pc_s;
                            req_q      <= 1'b1;
                            state_q    <= ST_REQ;
                        end else if (mem_err_in) begin
                            fetch_pc_q <= pc_inc_s;
                            req_q      <= 1'b0;
                            state_q    <= ST_HALT;
                        end else if (free_after_s) begin
                            fetch_pc_q <= pc_inc_s;
                            addr_q     <= pc_inc_s;
                            req_q      <= 1'b1;
                            state_q    <= ST_REQ;
                        end else begin
                            fetch_pc_q <= pc_inc_s;
                            req_q      <= 1'b0;
                            state_q    <= ST_IDLE;
                        end
                    end else if (redirect_in) begin
                        // The bus transaction must complete; its data is dropped in DRAIN.
                        fetch_pc_q <= redirect_pc_s;
                        state_q    <= ST_DRAIN;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack_in) begin
                        fetch_pc_q <= redirect_in ? redirect_pc_s : fetch_pc_q;
                        addr_q     <= redirect_in ? redirect_pc_s : fetch_pc_q;
                        req_q      <= 1'b1;
                        state_q    <= ST_REQ;
                    end else if (redirect_in) begin
                        fetch_pc_q <= redirect_pc_s;
                        state_q    <= ST_DRAIN;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    if (redirect_in) begin
                        fetch_pc_q <= redirect_pc_s;
                        addr_q     <= redirect_pc_s;
                        req_q      <= 1'b1;
                        state_q    <= ST_REQ;
                    end else begin
                        req_q   <= 1'b0;
                        state_q <= ST_HALT;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_out      = req_q;
    assign mem_addr_out     = addr_q;
    assign inst_valid_out   = valid_s;
    assign inst_out         = valid_s ? fifo_data_q[rd_ptr_q] : 32'h0000_0000;
    assign inst_pc_out      = valid_s ? fifo_pc_q[rd_ptr_q]   : 32'h0000_0000;
    assign flag_bus_err_out = valid_s ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule
